// File: rtl/uart_cmd_master_if.sv
// Word-level UART bridge and memory port bundle for the command master.
// The master modport is the command engine side; slave is the bridge/memory side.
interface uart_cmd_master_if;
   logic        uart_rx_empty;
   logic        uart_read;
   logic        uart_read_response;
   logic [31:0] uart_read_data;
   logic        uart_write;
   logic [31:0] uart_write_data;
   logic        uart_write_response;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      input  uart_rx_empty, uart_read_response, uart_read_data,
      input  uart_write_response, mem_ack, mem_rdata,
      output uart_read, uart_write, uart_write_data,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output uart_rx_empty, uart_read_response, uart_read_data,
      output uart_write_response, mem_ack, mem_rdata,
      input  uart_read, uart_write, uart_write_data,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/uart_cmd_master.sv
// Command engine: pulls command words from the UART bridge, runs ping/read/write
// on the memory port and returns one reply word per command.
module uart_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ACK_WORD       = 32'h0000_0001,
   parameter logic [31:0] NACK_WORD      = 32'hFFFF_FFFF
) (
   input  logic       clk,
   input  logic       reset,
   uart_cmd_master_if.master bus,
   output logic       busy,
   output logic [7:0] error_count
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] OP_PING  = 8'h50;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] OP_WRITE = 8'h57;

   typedef enum logic [3:0] {
      IDLE, RX_REQ, RX_WAIT, RX_DRAIN, DECODE,
      MEM, TX_REQ, TX_WAIT, TX_DRAIN
   } state_t;

   state_t        state, state_nx;
   logic [1:0]    idx;
   logic [7:0]    opc;
   logic [31:0]   addr_q, wdata_q, reply_q;
   logic [TW-1:0] tcnt;
   logic [7:0]    err_q;

   logic is_ping, is_read, is_write, need_more, tmo;

   assign is_ping   = (opc == OP_PING);
   assign is_read   = (opc == OP_READ);
   assign is_write  = (opc == OP_WRITE);
   assign need_more = is_write && (idx == 2'd1);
   assign tmo       = (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     if (!bus.uart_rx_empty) state_nx = RX_REQ;
         RX_REQ:   state_nx = RX_WAIT;
         RX_WAIT:  if (bus.uart_read_response) state_nx = RX_DRAIN;
         RX_DRAIN: begin
            if (!bus.uart_read_response) begin
               if (idx == 2'd0)    state_nx = DECODE;
               else if (need_more) state_nx = RX_REQ;
               else                state_nx = MEM;
            end
         end
         DECODE: begin
            unique case (1'b1)
               is_read, is_write: state_nx = RX_REQ;
               default:           state_nx = TX_REQ;
            endcase
         end
         MEM:      if (bus.mem_ack || tmo) state_nx = TX_REQ;
         TX_REQ:   state_nx = TX_WAIT;
         TX_WAIT:  if (bus.uart_write_response) state_nx = TX_DRAIN;
         TX_DRAIN: if (!bus.uart_write_response) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.uart_read       = (state == RX_REQ);
      bus.uart_write      = (state == TX_REQ);
      bus.uart_write_data = reply_q;
      bus.mem_req         = (state == MEM);
      bus.mem_we          = (state == MEM) && is_write;
      bus.mem_addr        = addr_q;
      bus.mem_wdata       = wdata_q;
      busy                = (state != IDLE);
      error_count         = err_q;
   end

   // Datapath: operand slots, reply word, timeout counter, error counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx     <= 2'd0;
         opc     <= 8'h00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         reply_q <= 32'h0;
         tcnt    <= '0;
         err_q   <= 8'h00;
      end else begin
         tcnt <= (state == MEM) ? tcnt + TW'(1) : '0;
         unique case (state)
            IDLE: idx <= 2'd0;
            RX_WAIT: begin
               if (bus.uart_read_response) begin
                  unique case (idx)
                     2'd0:    opc     <= bus.uart_read_data[31:24];
                     2'd1:    addr_q  <= bus.uart_read_data;
                     default: wdata_q <= bus.uart_read_data;
                  endcase
               end
            end
            RX_DRAIN: begin
               if (!bus.uart_read_response && idx != 2'd0 && need_more)
                  idx <= idx + 2'd1;
            end
            DECODE: begin
               unique case (1'b1)
                  is_ping: reply_q <= ACK_WORD;
                  is_read, is_write: idx <= 2'd1;
                  default: begin
                     reply_q <= NACK_WORD;
                     if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                  end
               endcase
            end
            MEM: begin
               if (bus.mem_ack) begin
                  reply_q <= is_write ? ACK_WORD : bus.mem_rdata;
               end else if (tmo) begin
                  reply_q <= NACK_WORD;
                  if (err_q != 8'hFF) err_q <= err_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/uart_cmd_master.md
# uart_cmd_master

Initiator-side command engine that drives the word interface of the UART bridge (read/write requests, response handshakes) from the fabric side. It pulls 32-bit command words received over serial, decodes them into ping, memory-read and memory-write operations on a simple request/acknowledge memory port, and sends a 32-bit reply word back through the UART. It sits between the UART bridge and the controller's memory bus, giving the host a word-level remote access channel.

## Interface
- TIMEOUT_CYCLES, 1024, maximum cycles spent in MEM waiting for mem_ack (≥1).
- ACK_WORD, 32'h00000001, reply for successful ping and write.
- NACK_WORD, 32'hFFFFFFFF, reply for unknown opcode or memory timeout.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- uart_rx_empty  in  1  UART receive FIFO empty.
- uart_read  out  1  one-cycle pulse requesting one received word.
- uart_read_response  in  1  high 2 consecutive cycles when uart_read_data is valid.
- uart_read_data  in  32  received word, MSB byte first on the line.
- uart_write  out  1  one-cycle pulse requesting transmission of uart_write_data.
- uart_write_data  out  32  reply word; held stable from uart_write until the response is seen.
- uart_write_response  in  1  high 2 consecutive cycles when the word is queued.
- mem_req  out  1  memory request, held until mem_ack or timeout.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  memory completion; mem_rdata valid same cycle.
- mem_rdata  in  32  memory read data.
- busy  out  1  high in every state except IDLE.
- error_count  out  8  saturating count of NACK replies.

## Operation
- Command word: opcode = bits[31:24]; bits[23:0] ignored. 0x50 PING (no operands), 0x52 READ (1 operand: address), 0x57 WRITE (2 operands: address, then data). Any other opcode is unknown.
- States, one cycle minimum each: IDLE, RX_REQ, RX_WAIT, RX_DRAIN, DECODE, MEM, TX_REQ, TX_WAIT, TX_DRAIN.
- IDLE: when uart_rx_empty=0, go to RX_REQ with word index 0.
- RX_REQ: uart_read=1 for exactly this cycle; go to RX_WAIT.
- RX_WAIT: on first uart_read_response=1 cycle, capture uart_read_data into slot (index 0 command, 1 address, 2 data); go to RX_DRAIN. No timeout.
- RX_DRAIN: stay while uart_read_response=1; then if index 0 go to DECODE; else if more operands needed, increment index and go to RX_REQ; else go to MEM.
- DECODE: PING → reply=ACK_WORD, TX_REQ. READ/WRITE → index 1, RX_REQ. Unknown → reply=NACK_WORD, error_count+1, TX_REQ. Unknown opcodes consume no operand words.
- MEM: mem_req=1, mem_we=1 for WRITE; timeout counter cleared on entry. On mem_ack: reply = ACK_WORD (WRITE) or mem_rdata (READ), mem_req drops next cycle, go to TX_REQ. If TIMEOUT_CYCLES cycles elapse without mem_ack: mem_req drops, reply=NACK_WORD, error_count+1, TX_REQ. mem_ack outside MEM ignored.
- TX_REQ: uart_write=1 for exactly this cycle with reply on uart_write_data; go to TX_WAIT. TX_WAIT: wait for uart_write_response=1 → TX_DRAIN. TX_DRAIN: stay while response high, then IDLE.
- error_count saturates at 255, never wraps; cleared only by reset.
- uart_read and uart_write are never high together and never re-pulsed before the previous response has fully deasserted.

## Timing
- Reset: state IDLE; uart_read, uart_write, mem_req, mem_we, busy = 0; uart_write_data, mem_addr, mem_wdata = 0; error_count = 0; operand slots cleared. Reset mid-operation aborts immediately (mem_req drops the next cycle); no reply is sent for the aborted command.
- All outputs registered (Moore from state/registers).
- With a 2-cycle response pulse whose first cycle is N: RX_DRAIN at N+1, leaves at N+2, DECODE at N+3; for PING/unknown, uart_write high at N+4.
- MEM: mem_req rises the cycle after RX_DRAIN exits; ack in cycle M → TX_REQ (uart_write=1) at M+1.
- Timeout: mem_req high exactly TIMEOUT_CYCLES cycles when no ack arrives.
- mem_addr/mem_wdata stable for the whole MEM state.

## Test plan
- PING: feed 0x50000000 → exactly one uart_write with uart_write_data=0x00000001, mem_req never asserted, busy returns 0 after TX_DRAIN.
- WRITE: feed 0x57000000, 0x00000100, 0xDEADBEEF; ack 3 cycles after mem_req → mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, reply 0x00000001.
- READ: feed 0x52000000, 0x00000040; mem_rdata=0xCAFEF00D with ack → mem_we=0, reply 0xCAFEF00D; exactly two uart_read pulses.
- Unknown: feed 0xFF000000 → reply 0xFFFFFFFF, error_count=1, next word treated as a new command.
- Timeout: TIMEOUT_CYCLES=16, READ with no ack → mem_req high exactly 16 cycles, reply 0xFFFFFFFF, error_count increments; 300 unknown commands → error_count holds 255.
- Reset in MEM: assert reset while mem_req=1 → next cycle all outputs 0, no uart_write; following PING answered with 0x00000001.
